// File: rtl/apb_mem_completer.sv
// APB completer backed by a DEPTH-word register-file memory.
// Programmable wait states, error response for out-of-range word addresses,
// and a saturating count of committed writes.
module apb_mem_completer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Pclk,
  input  logic              Preset,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic [DATA_W-1:0] Pdata,
  input  logic [3:0]        wait_cfg,
  output logic              Pready,
  output logic [DATA_W-1:0] Prdata,
  output logic              Pslverr,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [3:0]        r_cnt;
  logic              r_ready;
  logic              r_slverr;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_wr_count;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_rsp_addr;
  logic              w_rsp_write;
  logic              w_rsp_err;
  logic [IDX_W-1:0]  w_rsp_idx;
  logic [IDX_W-1:0]  w_wr_idx;

  // Response source: on the SETUP->ACCESS edge the latch is being loaded in
  // the same cycle, so the zero-wait response is built from the live bus.
  always_comb begin
    w_rsp_addr  = r_addr;
    w_rsp_write = r_write;
    if (r_state == ST_SETUP) begin
      w_rsp_addr  = Paddr;
      w_rsp_write = Pwrite;
    end
    w_rsp_err = (w_rsp_addr >= ADDR_W'(DEPTH));
    w_rsp_idx = w_rsp_addr[IDX_W-1:0];
    w_wr_idx  = r_addr[IDX_W-1:0];
  end

  // Transfer FSM, wait counter, registered response and memory.
  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_slverr   <= 1'b0;
      r_rdata    <= '0;
      r_wr_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Psel & Penable without a setup phase is ignored.
          if (Psel && !Penable) begin
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!Psel) begin
            r_state <= ST_IDLE;
          end else begin
            r_addr  <= Paddr;
            r_wdata <= Pdata;
            r_write <= Pwrite;
            if (Penable) begin
              r_state <= ST_ACCESS;
              r_cnt   <= wait_cfg;
              if (wait_cfg == 4'd0) begin
                r_ready  <= 1'b1;
                r_slverr <= w_rsp_err;
                if (w_rsp_err) begin
                  r_rdata <= '0;
                end else if (!w_rsp_write) begin
                  r_rdata <= r_mem[w_rsp_idx];
                end
              end
            end
          end
        end
        ST_ACCESS: begin
          if (!(Psel && Penable)) begin
            // Abort: no commit, no count.
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
          end else if (r_ready) begin
            if (r_write && !r_slverr) begin
              r_mem[w_wr_idx] <= r_wdata;
              if (r_wr_count != '1) begin
                r_wr_count <= r_wr_count + 1'b1;
              end
            end
            r_state  <= ST_IDLE;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_ready  <= 1'b1;
              r_slverr <= w_rsp_err;
              if (w_rsp_err) begin
                r_rdata <= '0;
              end else if (!w_rsp_write) begin
                r_rdata <= r_mem[w_rsp_idx];
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Pready   = r_ready;
  assign Pslverr  = r_slverr;
  assign Prdata   = r_rdata;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Self-checking bench for apb_mem_completer: scoreboarded APB master with a
// reference memory model, wait-state latency, error, abort and reset checks.
module tb_apb_mem_completer;

  logic        Pclk;
  logic        Preset;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pdata;
  logic [3:0]  wait_cfg;
  logic        Pready;
  logic [31:0] Prdata;
  logic        Pslverr;
  logic [15:0] wr_count;

  apb_mem_completer #(
    .DATA_W(32),
    .ADDR_W(32),
    .DEPTH (16),
    .CNT_W (16)
  ) dut (
    .Pclk    (Pclk),
    .Preset  (Preset),
    .Psel    (Psel),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pdata   (Pdata),
    .wait_cfg(wait_cfg),
    .Pready  (Pready),
    .Prdata  (Prdata),
    .Pslverr (Pslverr),
    .wr_count(wr_count)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned waits;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_mem [16];
  int unsigned m_cnt;
  int unsigned n_tests;
  int unsigned n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer, entered and left at a falling edge. abort_at>0 drops
  // Psel/Penable in that ACCESS cycle instead of completing.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] wcfg, input int unsigned abort_at);
    exp_t        e;
    exp_t        g;
    int unsigned n;
    logic        done;
    logic        stray;
    int unsigned cnt0;
    e.is_wr = wr;
    e.addr  = addr;
    e.wdata = data;
    e.err   = (addr >= 32'd16);
    e.waits = wcfg;
    e.rdata = (e.err || wr) ? 32'h0 : m_mem[addr[3:0]];
    if (abort_at == 0) sb.push_back(e);
    cnt0     = m_cnt;
    Psel     = 1'b1;
    Penable  = 1'b0;
    Pwrite   = wr;
    Paddr    = addr;
    Pdata    = data;
    wait_cfg = wcfg;
    @(negedge Pclk);
    Penable = 1'b1;
    n    = 0;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge Pclk);
      if (abort_at != 0 && c == int'(abort_at)) begin
        check("abort_ready_before_drop", {63'd0, Pready}, 64'd0);
        Psel    = 1'b0;
        Penable = 1'b0;
        done    = 1'b1;
      end else if (Pready) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          check("sb_nonempty", 64'd0, 64'd1);
        end else begin
          g = sb.pop_front();
          check("ready_latency", 64'(n), 64'(g.waits));
          check("slverr", {63'd0, Pslverr}, {63'd0, g.err});
          if (!g.is_wr) check("rdata", {32'd0, Prdata}, {32'd0, g.rdata});
          if (g.is_wr && !g.err) begin
            m_mem[g.addr[3:0]] = g.wdata;
            if (m_cnt != 32'hFFFF) m_cnt++;
          end
        end
      end else begin
        n++;
        // Latched copies must be used during ACCESS.
        Paddr    = $urandom;
        Pdata    = $urandom;
        Pwrite   = ~wr;
        wait_cfg = 4'($urandom);
      end
    end
    if (!done) check("ready_timeout", 64'd1, 64'd0);
    if (abort_at != 0) begin
      stray = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge Pclk);
        if (Pready) stray = 1'b1;
      end
      check("abort_no_ready", {63'd0, stray}, 64'd0);
      check("abort_wr_count", {48'd0, wr_count}, 64'(cnt0));
    end else begin
      @(negedge Pclk);
      Psel    = 1'b0;
      Penable = 1'b0;
      check("wr_count", {48'd0, wr_count}, 64'(m_cnt));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pready"},   {63'd0, Pready},   64'd0);
    check({tag, "_prdata"},   {32'd0, Prdata},   64'd0);
    check({tag, "_pslverr"},  {63'd0, Pslverr},  64'd0);
    check({tag, "_wr_count"}, {48'd0, wr_count}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stray;
    n_tests  = 0;
    n_fail   = 0;
    m_cnt    = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    Preset   = 1'b1;
    Psel     = 1'b0;
    Penable  = 1'b0;
    Pwrite   = 1'b0;
    Paddr    = '0;
    Pdata    = '0;
    wait_cfg = '0;
    repeat (2) @(negedge Pclk);
    check_outputs_zero("reset");
    Preset = 1'b0;
    @(negedge Pclk);

    // Zero wait states, write then read.
    apb_xfer(1'b1, 32'd0, 32'h1111_1111, 4'd0, 0);
    apb_xfer(1'b0, 32'd0, 32'h0,         4'd0, 0);

    // Three wait states.
    apb_xfer(1'b1, 32'd1, 32'h2222_2222, 4'd3, 0);
    apb_xfer(1'b0, 32'd1, 32'h0,         4'd3, 0);

    // Fill 0..14 back to back, then read everything back.
    for (int k = 1; k <= 15; k++) begin
      apb_xfer(1'b1, 32'(k - 1), 32'h1111_1111 * 32'(k), 4'($urandom_range(0, 2)), 0);
    end
    for (int k = 0; k < 16; k++) begin
      apb_xfer(1'b0, 32'(k), 32'h0, 4'($urandom_range(0, 2)), 0);
    end

    // Out-of-range write and reads.
    apb_xfer(1'b1, 32'd16,         32'hDEAD_BEEF, 4'd1, 0);
    apb_xfer(1'b0, 32'd16,         32'h0,         4'd0, 0);
    apb_xfer(1'b1, 32'hFFFF_FFF0,  32'hCAFE_F00D, 4'd2, 0);
    apb_xfer(1'b0, 32'd15,         32'h0,         4'd0, 0);

    // Abort a 5-wait write in its second ACCESS cycle; mem[2] must keep its value.
    apb_xfer(1'b1, 32'd2, 32'hBAD0_BAD0, 4'd5, 2);
    apb_xfer(1'b0, 32'd2, 32'h0,         4'd1, 0);

    // Asynchronous reset in the middle of a 4-wait write.
    Psel     = 1'b1;
    Penable  = 1'b0;
    Pwrite   = 1'b1;
    Paddr    = 32'd3;
    Pdata    = 32'h5555_5555;
    wait_cfg = 4'd4;
    @(negedge Pclk);
    Penable = 1'b1;
    repeat (2) @(negedge Pclk);
    #2 Preset = 1'b1;
    #1 check_outputs_zero("async_reset");
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    m_cnt = 0;
    @(negedge Pclk);
    Preset  = 1'b0;
    Psel    = 1'b0;
    Penable = 1'b0;
    @(negedge Pclk);

    // Psel & Penable in IDLE without a setup phase is ignored.
    Psel    = 1'b1;
    Penable = 1'b1;
    Pwrite  = 1'b1;
    Paddr   = 32'd4;
    Pdata   = 32'h7777_7777;
    stray   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Pclk);
      if (Pready) stray = 1'b1;
    end
    check("idle_penable_ignored", {63'd0, stray}, 64'd0);
    Psel    = 1'b0;
    Penable = 1'b0;
    @(negedge Pclk);

    apb_xfer(1'b0, 32'd3, 32'h0, 4'd0, 0);
    apb_xfer(1'b0, 32'd4, 32'h0, 4'd2, 0);
    apb_xfer(1'b0, 32'd0, 32'h0, 4'd1, 0);

    // Read-after-write back to back after reset.
    apb_xfer(1'b1, 32'd7, 32'hA5A5_5A5A, 4'd0, 0);
    apb_xfer(1'b0, 32'd7, 32'h0,         4'd0, 0);

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
